// File: rtl/sorted_array_streamer_pkg.sv
// Shared constants and FSM state encoding for the sorted array streamer.
package sorted_array_streamer_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultDepth = 4;

  // FSM state encoding: IDLE, SORT, STREAM.
  typedef logic [1:0] state_t;
  localparam state_t StIdle   = 2'd0;
  localparam state_t StSort   = 2'd1;
  localparam state_t StStream = 2'd2;

endpackage

// File: rtl/sorted_array_streamer_sort_compare_swap.sv
// Combinational compare-and-swap cell: orders two unsigned values.
// Equal inputs pass straight through, so equal elements never move.
module sort_compare_swap #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  logic swap;

  // Swap only when the lower-index element is strictly greater.
  always_comb begin
    swap = (a > b);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end

endmodule

// File: rtl/sorted_array_streamer.sv
// Captures a frame of DEPTH elements, sorts it with DEPTH odd-even transposition
// passes (one per cycle), then streams the elements out in ascending order.
module sorted_array_streamer
  import sorted_array_streamer_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = DefaultDepth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [DATA_W*DEPTH-1:0] load_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  output logic                    busy
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int NumCmp = DEPTH / 2;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] arr_q [DEPTH];
  logic [DATA_W-1:0] arr_d [DEPTH];
  logic [IdxW-1:0]   pass_q, pass_d;
  logic [IdxW-1:0]   rd_q, rd_d;

  logic [DATA_W-1:0] cmp_a  [NumCmp];
  logic [DATA_W-1:0] cmp_b  [NumCmp];
  logic [DATA_W-1:0] cmp_lo [NumCmp];
  logic [DATA_W-1:0] cmp_hi [NumCmp];
  logic              odd_pass;

  assign odd_pass = pass_q[0];

  // One bank of DEPTH/2 comparators is shared by both pass types: even passes
  // use pairs (2k,2k+1), odd passes (2k+1,2k+2). On odd passes the last cell
  // wraps to element 0 and its result is discarded.
  for (genvar k = 0; k < NumCmp; k++) begin : g_cmp
    localparam int EvenA = 2 * k;
    localparam int EvenB = 2 * k + 1;
    localparam int OddA  = 2 * k + 1;
    localparam int OddB  = (2 * k + 2) % DEPTH;

    assign cmp_a[k] = odd_pass ? arr_q[OddA] : arr_q[EvenA];
    assign cmp_b[k] = odd_pass ? arr_q[OddB] : arr_q[EvenB];

    sort_compare_swap #(
      .DATA_W(DATA_W)
    ) u_cmp (
      .a (cmp_a[k]),
      .b (cmp_b[k]),
      .lo(cmp_lo[k]),
      .hi(cmp_hi[k])
    );
  end

  // Next-state logic: capture, sort passes and read index advance.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    rd_d    = rd_q;
    arr_d   = arr_q;
    case (state_q)
      StIdle: begin
        if (load_valid) begin
          for (int i = 0; i < DEPTH; i++) begin
            arr_d[i] = load_data[i*DATA_W +: DATA_W];
          end
          pass_d  = '0;
          state_d = StSort;
        end
      end
      StSort: begin
        for (int k = 0; k < NumCmp; k++) begin
          if (!odd_pass) begin
            arr_d[2*k]   = cmp_lo[k];
            arr_d[2*k+1] = cmp_hi[k];
          end else if (k < NumCmp - 1) begin
            arr_d[2*k+1]             = cmp_lo[k];
            arr_d[(2*k+2) % DEPTH]   = cmp_hi[k];
          end
        end
        pass_d = pass_q + 1'b1;
        if (pass_q == LastIdx) begin
          pass_d  = '0;
          rd_d    = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (out_ready) begin
          if (rd_q == LastIdx) begin
            rd_d    = '0;
            state_d = StIdle;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset that also flushes the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pass_q  <= '0;
      rd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        arr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      rd_q    <= rd_d;
      arr_q   <= arr_d;
    end
  end

  // Outputs decoded from the current state; out_data is zero when not streaming.
  always_comb begin
    load_ready = (state_q == StIdle);
    out_valid  = (state_q == StStream);
    out_last   = out_valid && (rd_q == LastIdx);
    out_data   = out_valid ? arr_q[rd_q] : '0;
    busy       = (state_q != StIdle);
  end

endmodule

// File: tb/tb_sorted_array_streamer.sv
// Directed bench for sorted_array_streamer (DATA_W=8, DEPTH=4).
module tb_sorted_array_streamer;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;

  logic [7:0] rx_data [4];
  logic       rx_last [4];
  int         rx_got;

  sorted_array_streamer #(
    .DATA_W(8),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Offer a frame while IDLE; returns #1 after the handshake edge.
  task automatic load_frame(input logic [31:0] d);
    load_valid = 1'b1;
    load_data  = d;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  // Collect n elements with out_ready held high, bounded in cycles.
  task automatic recv(input int n);
    int cyc;
    cyc    = 0;
    rx_got = 0;
    out_ready = 1'b1;
    while (rx_got < n && cyc < 60) begin
      if (out_valid) begin
        rx_data[rx_got] = out_data;
        rx_last[rx_got] = out_last;
        rx_got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_valid = 1'b0;
    load_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (load_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        out_data !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b last=%b data=%h busy=%b want 1 0 0 00 0",
               load_ready, out_valid, out_last, out_data, busy);
    end
  endtask

  task automatic test_mixed();
    logic [7:0] exp [4] = '{8'h00, 8'h03, 8'h10, 8'hFF};
    int n;
    load_frame(32'h10_03_FF_00);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n !== 4) begin
      bad++;
      $display("FAIL mixed_latency: got %0d edges want 4", n);
    end
    recv(4);
    total++;
    if (rx_got !== 4) begin
      bad++;
      $display("FAIL mixed_count: got %0d want 4", rx_got);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rx_data[i] !== exp[i] || rx_last[i] !== (i == 3)) begin
        bad++;
        $display("FAIL mixed_elem%0d: got %h last=%b want %h last=%b",
                 i, rx_data[i], rx_last[i], exp[i], (i == 3));
      end
    end
    total++;
    if (load_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mixed_idle: got rdy=%b busy=%b want 1 0", load_ready, busy);
    end
  endtask

  task automatic test_reverse();
    logic [7:0] exp [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_frame(32'h01_02_03_04);
    recv(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= rx_got || rx_data[i] !== exp[i]) begin
        bad++;
        $display("FAIL reverse_elem%0d: got %h want %h", i, rx_data[i], exp[i]);
      end
    end
  endtask

  task automatic test_duplicates();
    logic [7:0] exp [4] = '{8'h02, 8'h02, 8'h07, 8'h07};
    load_frame(32'h05_05_05_05);
    recv(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= rx_got || rx_data[i] !== 8'h05) begin
        bad++;
        $display("FAIL dup5_elem%0d: got %h want 05", i, rx_data[i]);
      end
    end
    load_frame(32'h07_02_07_02);
    recv(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= rx_got || rx_data[i] !== exp[i]) begin
        bad++;
        $display("FAIL dup72_elem%0d: got %h want %h", i, rx_data[i], exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [3] = '{8'h20, 8'h30, 8'h40};
    int n;
    out_ready = 1'b1;
    load_frame(32'h10_40_20_30);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (out_data !== 8'h10) begin
      bad++;
      $display("FAIL bp_first: got %h want 10", out_data);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h20 || out_last !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got vld=%b data=%h last=%b want 1 20 0",
                 i, out_valid, out_data, out_last);
      end
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    recv(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= rx_got || rx_data[i] !== exp[i] || rx_last[i] !== (i == 2)) begin
        bad++;
        $display("FAIL bp_rest%0d: got %h last=%b want %h last=%b",
                 i, rx_data[i], rx_last[i], exp[i], (i == 2));
      end
    end
  endtask

  task automatic test_protocol();
    logic [7:0] exp_a [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] exp_b [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    int t_a, t_b, got, cyc, rdy_bad;
    out_ready  = 1'b1;
    load_valid = 1'b1;
    load_data  = 32'h04_03_02_01;
    @(posedge clk);
    #1;
    t_a = cyc_cnt;
    load_data = 32'h0A_0B_0C_0D;
    got = 0;
    cyc = 0;
    rdy_bad = 0;
    while (got < 4 && cyc < 40) begin
      if (load_ready !== 1'b0) rdy_bad++;
      if (out_valid) begin
        total++;
        if (out_data !== exp_a[got]) begin
          bad++;
          $display("FAIL proto_a%0d: got %h want %h", got, out_data, exp_a[got]);
        end
        got++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    total++;
    if (rdy_bad !== 0 || got !== 4) begin
      bad++;
      $display("FAIL proto_busy: got rdy_high=%0d elems=%0d want 0 4", rdy_bad, got);
    end
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL proto_idle_rdy: got %b want 1", load_ready);
    end
    @(posedge clk);
    #1;
    t_b = cyc_cnt;
    load_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || (t_b - t_a) !== 9) begin
      bad++;
      $display("FAIL proto_b_accept: got busy=%b gap=%0d want 1 9", busy, t_b - t_a);
    end
    recv(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= rx_got || rx_data[i] !== exp_b[i]) begin
        bad++;
        $display("FAIL proto_b%0d: got %h want %h", i, rx_data[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [4] = '{8'h01, 8'h02, 8'h08, 8'h09};
    int leak;
    load_frame(32'h80_70_60_50);
    recv(2);
    total++;
    if (rx_got !== 2 || rx_data[0] !== 8'h50 || rx_data[1] !== 8'h60) begin
      bad++;
      $display("FAIL rstmid_pre: got n=%0d %h %h want 2 50 60", rx_got, rx_data[0], rx_data[1]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0 ||
        out_data !== 8'h00 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_state: got vld=%b rdy=%b busy=%b data=%h last=%b want 0 1 0 00 0",
               out_valid, load_ready, busy, out_data, out_last);
    end
    leak = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) leak++;
    end
    total++;
    if (leak !== 0) begin
      bad++;
      $display("FAIL rstmid_leak: got %0d valid cycles want 0", leak);
    end
    load_frame(32'h09_01_08_02);
    recv(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= rx_got || rx_data[i] !== exp[i] || rx_last[i] !== (i == 3)) begin
        bad++;
        $display("FAIL rstmid_new%0d: got %h last=%b want %h last=%b",
                 i, rx_data[i], rx_last[i], exp[i], (i == 3));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    load_valid = 1'b0;
    load_data = '0;
    out_ready = 1'b0;
    test_reset();
    test_mixed();
    test_reverse();
    test_duplicates();
    test_backpressure();
    test_protocol();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
